lsu_stim_pipe: RTL

//  Parametrised stimulus/check harness for the lsu. Queues one request per cycle, drives it

---
 rtl/lsu_stim_pipe_pkg.sv | 54 +++++
 rtl/lsu_stim_fifo.sv | 45 ++++
 rtl/lsu_stim_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_stim_pipe_pkg.sv
// Shared types and helpers for the lsu stimulus/check pipe.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package lsu_stim_pipe_pkg;

    // lsu mem_type encodings
    localparam logic [1:0] MEM_TYPE_B = 2'd0;
    localparam logic [1:0] MEM_TYPE_H = 2'd1;
    localparam logic [1:0] MEM_TYPE_W = 2'd2;

    // Way field is sized for the largest harness we build; unused upper bits stay 0.
    localparam int PORT_W_MAX = 4;

    typedef struct packed {
        logic [PORT_W_MAX-1:0] port;
        logic                  write;
        logic [1:0]            size;
        logic [31:0]           addr;
        logic [31:0]           wdata;
    } stim_req_t;

    // Size 3 is illegal; half/word must be naturally aligned.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            MEM_TYPE_B: ok = 1'b1;
            MEM_TYPE_H: ok = ~lo[0];
            MEM_TYPE_W: ok = (lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            MEM_TYPE_B: be = 4'b0001 << lo;
            MEM_TYPE_H: be = 4'b0011 << lo;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            MEM_TYPE_B: m = 32'h0000_00FF;
            MEM_TYPE_H: m = 32'h0000_FFFF;
            default:    m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_stim_fifo.sv
// Generic synchronous FIFO, DEPTH entries (power of 2, >=2) of type T.
// Latency: a push is visible at head_dat the cycle after it is written (no bypass).
// Backpressure: pushes while full and pops while empty are ignored; full/empty come only from pointer registers.
module lsu_stim_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_dat,
    input  logic pop,
    output T     head_dat,
    output logic full,
    output logic empty
);
    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = 1;

    T            mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/lsu_stim_pipe.sv
// Stimulus/check harness for the lsu: queues requests, walks them down M0 (queue head, vaddr),
// M1 (valid/paddr) and M2 (wdata, rdata check). Latency: accept -> head >=1 cycle, head -> retire 2 unstalled cycles.
// Backpressure: req_ready_o drops when the queue is full; stall_i | lsu_busy_i freezes head, M1 and M2.
// Ports: clk/rst (sync, active-high); req_* request side; stall_i/lsu_busy_i stall sources;
//        lsu_* drive/return the lsu ways; pipe_stall_o, err_cnt_o, first_err_o, retired_o, drop_cnt_o status.
module lsu_stim_pipe
    import lsu_stim_pipe_pkg::*;
#(
    parameter int PORT_NUM   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SHADOW_AW  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [$clog2(PORT_NUM)-1:0]   req_port_i,
    input  logic                          req_write_i,
    input  logic [1:0]                    req_size_i,
    input  logic [31:0]                   req_addr_i,
    input  logic [31:0]                   req_wdata_i,
    input  logic                          stall_i,
    input  logic                          lsu_busy_i,
    output logic [PORT_NUM-1:0]           lsu_valid_o,
    output logic                          lsu_write_o,
    output logic [1:0]                    lsu_size_o,
    output logic [31:0]                   lsu_vaddr_o,
    output logic [31:0]                   lsu_paddr_o,
    output logic [31:0]                   lsu_wdata_o,
    input  logic [PORT_NUM-1:0][31:0]     lsu_rdata_i,
    output logic                          pipe_stall_o,
    output logic [15:0]                   err_cnt_o,
    output logic [31:0]                   first_err_o,
    output logic [31:0]                   retired_o,
    output logic [15:0]                   drop_cnt_o
);
    localparam int PW = $clog2(PORT_NUM);

    stim_req_t in_req, head, m1, m2;
    logic      q_full, q_empty, accept, legal, push, drop, pop;
    logic      m1_vld, m2_vld;

    assign pipe_stall_o = stall_i | lsu_busy_i;
    assign req_ready_o  = ~q_full;
    assign accept       = req_valid_i & ~q_full;
    assign legal        = req_legal(req_size_i, req_addr_i[1:0]);
    assign push         = accept & legal;
    assign drop         = accept & ~legal;
    assign pop          = ~pipe_stall_o & ~q_empty;

    always_comb begin
        in_req       = '0;
        in_req.port  = PORT_W_MAX'(req_port_i);
        in_req.write = req_write_i;
        in_req.size  = req_size_i;
        in_req.addr  = req_addr_i;
        in_req.wdata = req_wdata_i;
    end

    lsu_stim_fifo #(.DEPTH(FIFO_DEPTH), .T(stim_req_t)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (in_req),
        .pop      (pop),
        .head_dat (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Queue head is the M0 stage: its address is presented as vaddr.
    assign lsu_vaddr_o = q_empty ? 32'd0 : head.addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_vld <= 1'b0;
            m1     <= '0;
            m2_vld <= 1'b0;
            m2     <= '0;
        end else if (!pipe_stall_o) begin
            m1_vld <= ~q_empty;
            m1     <= q_empty ? '0 : head;
            m2_vld <= m1_vld;
            m2     <= m1;
        end
    end

    always_comb begin
        lsu_valid_o = '0;
        if (m1_vld) lsu_valid_o[m1.port[PW-1:0]] = 1'b1;
    end
    assign lsu_write_o = m1.write;
    assign lsu_size_o  = m1.size;
    assign lsu_paddr_o = m1.addr;
    assign lsu_wdata_o = m2.wdata;

    // Upper way bits are always zero for this PORT_NUM.
    logic unused_port_bits;
    assign unused_port_bits = ^{m1.port, m2.port};

    // ---- shadow memory and retire check ----
    logic [31:0]              shadow [2**SHADOW_AW];
    logic [2**SHADOW_AW-1:0]  shadow_vld;
    logic                     retire, mismatch;
    logic [SHADOW_AW-1:0]     widx;
    logic [4:0]               lane_sh;
    logic [3:0]               be;
    logic [31:0]              wr_lanes, exp_dat, act_dat;

    assign retire   = m2_vld & ~pipe_stall_o;
    assign widx     = m2.addr[SHADOW_AW+1:2];
    assign lane_sh  = {m2.addr[1:0], 3'b000};
    assign be       = byte_en(m2.size, m2.addr[1:0]);
    assign wr_lanes = m2.wdata << lane_sh;
    // Load data comes back right-aligned, so bring the shadow lanes down to bit 0.
    assign exp_dat  = (shadow[widx] >> lane_sh) & size_mask(m2.size);
    assign act_dat  = lsu_rdata_i[m2.port[PW-1:0]] & size_mask(m2.size);
    assign mismatch = retire & ~m2.write & shadow_vld[widx] & (exp_dat != act_dat);

    always_ff @(posedge clk) begin
        if (retire && m2.write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) shadow[widx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_vld  <= '0;
            err_cnt_o   <= '0;
            first_err_o <= '0;
            retired_o   <= '0;
            drop_cnt_o  <= '0;
        end else begin
            if (retire && m2.write) shadow_vld[widx] <= 1'b1;
            if (retire) retired_o <= retired_o + 32'd1;
            if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            if (mismatch) begin
                if (err_cnt_o == 16'd0) first_err_o <= m2.addr;
                if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

endmodule
